// File: rtl/avr_vio.sv
// avr_vio: memory-mapped video/timer I/O on the AVR data bus (VRAM pointer, pixel writes, tick/IRQ).
// Define AVR_VIO_FIFO_EN for the buffered, back-pressured pixel path; otherwise writes go out unbuffered.
module avr_vio #(
  parameter logic [15:0] BASE       = 16'h0020,
  parameter int          AW         = 16,
  parameter int          DW         = 4,
  parameter int          ROW_STEP   = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_DIV   = 250,
  parameter logic [2:0]  IRQ_VECT   = 3'd1
) (
  input  logic          clock_25,
  input  logic          reset_n,
  input  logic [15:0]   address,
  input  logic          we,
  input  logic [7:0]    data_o,
  output logic [7:0]    data_rd,
  output logic          hit,
  output logic [AW-1:0] vram_a,
  output logic [DW-1:0] vram_d,
  output logic          vram_w,
  input  logic          vram_ready,
  output logic [3:0]    border,
  output logic [7:0]    vconfig,
  output logic          intr,
  output logic [2:0]    vect
);

  localparam int PSW = $clog2(TICK_DIV);

  logic [15:0]   w_off16;
  logic [2:0]    w_off;
  logic          w_wr;
  logic          w_data_wr;
  logic [15:0]   w_ptr_ext;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic          w_presc_wrap;
  logic          w_pend_set;
  logic          w_pend_nxt;
  logic          w_ovf_nxt;
  logic [7:0]    w_vcfg_nxt;
  logic [7:0]    w_status;

  logic [AW-1:0] r_ptr;
  logic [3:0]    r_border;
  logic [7:0]    r_vconfig;
  logic [15:0]   r_tick;
  logic [PSW-1:0] r_presc;
  logic [7:0]    r_shadow;
  logic          r_pend;
  logic          r_ovf;
  logic          r_intr;

  // Pointer advance: X-step and Y-step combine, DIR selects subtract; wraps modulo 2^AW.
  function automatic logic [AW-1:0] f_step(input logic [AW-1:0] ptr, input logic [7:0] cfg);
    logic [AW-1:0] delta;
    delta = (cfg[2] ? AW'(1) : '0) + (cfg[3] ? AW'(ROW_STEP) : '0);
    return cfg[4] ? ptr - delta : ptr + delta;
  endfunction

  assign w_off16      = address - BASE;
  assign hit          = (w_off16[15:3] == 13'd0);
  assign w_off        = w_off16[2:0];
  assign w_wr         = we && hit;
  assign w_data_wr    = w_wr && (w_off == 3'd2);
  assign w_ptr_ext    = 16'(r_ptr);
  assign w_presc_wrap = (r_presc == PSW'(TICK_DIV - 1));
  assign w_pend_set   = w_presc_wrap && (r_tick[7:0] == 8'hFF);
  assign w_status     = {4'b0000, r_ovf, r_pend, w_empty, w_full};

  assign border  = r_border;
  assign vconfig = r_vconfig;
  assign intr    = r_intr;
  assign vect    = IRQ_VECT;

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_nxt  = r_ovf;
    w_vcfg_nxt = r_vconfig;
    if (w_wr && (w_off == 3'd3)) begin
      if (data_o[2]) w_pend_nxt = 1'b0;
      if (data_o[3]) w_ovf_nxt  = 1'b0;
    end
    if (w_pend_set) w_pend_nxt = 1'b1;
    if (w_ovf_set)  w_ovf_nxt  = 1'b1;
    if (w_wr && (w_off == 3'd7)) w_vcfg_nxt = data_o;
  end

  always_comb begin
    data_rd = 8'h00;
    if (hit) begin
      case (w_off)
        3'd0:    data_rd = w_ptr_ext[7:0];
        3'd1:    data_rd = w_ptr_ext[15:8];
        3'd3:    data_rd = w_status;
        3'd4:    data_rd = r_tick[7:0];
        3'd5:    data_rd = r_shadow;
        3'd6:    data_rd = {4'b0000, r_border};
        3'd7:    data_rd = r_vconfig;
        default: data_rd = 8'h00;
      endcase
    end
  end

  // intr is registered from the next-state values so it follows the flag on the same edge.
  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_border  <= 4'h0;
      r_vconfig <= 8'h04;
      r_tick    <= 16'h0000;
      r_presc   <= '0;
      r_shadow  <= 8'h00;
      r_pend    <= 1'b0;
      r_ovf     <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_presc   <= w_presc_wrap ? '0 : r_presc + 1'b1;
      if (w_presc_wrap) r_tick <= r_tick + 16'd1;
      r_pend    <= w_pend_nxt;
      r_ovf     <= w_ovf_nxt;
      r_vconfig <= w_vcfg_nxt;
      r_intr    <= w_pend_nxt && w_vcfg_nxt[7];
      if (w_wr && (w_off == 3'd6)) r_border <= data_o[3:0];
      // Any cycle that presents TICK_L for reading snapshots the high byte.
      if (hit && !we && (w_off == 3'd4)) r_shadow <= r_tick[15:8];
      if (w_push)
        r_ptr <= f_step(r_ptr, r_vconfig);
      else if (w_wr && (w_off == 3'd0))
        r_ptr <= AW'({w_ptr_ext[15:8], data_o});
      else if (w_wr && (w_off == 3'd1))
        r_ptr <= AW'({data_o, w_ptr_ext[7:0]});
    end
  end

`ifdef AVR_VIO_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [AW+DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]      r_wr_idx;
  logic [PW:0]      r_rd_idx;
  logic             w_pop;

  assign w_empty   = (r_wr_idx == r_rd_idx);
  assign w_full    = (r_wr_idx[PW] != r_rd_idx[PW]) && (r_wr_idx[PW-1:0] == r_rd_idx[PW-1:0]);
  assign w_pop     = !w_empty && vram_ready;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_ovf_set = w_data_wr && !w_push;

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clock_25) begin
    if (w_push) r_mem[r_wr_idx[PW-1:0]] <= {r_ptr, data_o[DW-1:0]};
  end

  assign {vram_a, vram_d} = r_mem[r_rd_idx[PW-1:0]];
  assign vram_w           = !w_empty;
`else
  logic          r_vram_w;
  logic [AW-1:0] r_vram_a;
  logic [DW-1:0] r_vram_d;
  logic          w_unused_ready;

  assign w_unused_ready = vram_ready;
  assign w_empty        = 1'b1;
  assign w_full         = 1'b0;
  assign w_push         = w_data_wr;
  assign w_ovf_set      = 1'b0;

  always_ff @(posedge clock_25) begin
    if (!reset_n) r_vram_w <= 1'b0;
    else          r_vram_w <= w_data_wr;
  end

  always_ff @(posedge clock_25) begin
    if (w_data_wr) begin
      r_vram_a <= r_ptr;
      r_vram_d <= data_o[DW-1:0];
    end
  end

  assign vram_a = r_vram_a;
  assign vram_d = r_vram_d;
  assign vram_w = r_vram_w;
`endif

endmodule

// File: tb/tb_avr_vio.sv
// Directed bench for avr_vio: expected VRAM writes are queued by the stimulus and
// checked by an independent monitor; register reads are checked inline.
module tb_avr_vio;

  localparam logic [15:0] BASE = 16'h0020;
`ifdef AVR_VIO_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clock_25 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] address  = 16'h0000;
  logic        we       = 1'b0;
  logic [7:0]  data_o   = 8'h00;
  logic        vram_ready = 1'b1;
  logic [7:0]  data_rd;
  logic        hit;
  logic [15:0] vram_a;
  logic [3:0]  vram_d;
  logic        vram_w;
  logic [3:0]  border;
  logic [7:0]  vconfig;
  logic        intr;
  logic [2:0]  vect;

  int n_total = 0;
  int n_pass  = 0;
  logic [19:0] exp_q[$];

  avr_vio dut (
    .clock_25(clock_25), .reset_n(reset_n), .address(address), .we(we), .data_o(data_o),
    .data_rd(data_rd), .hit(hit), .vram_a(vram_a), .vram_d(vram_d), .vram_w(vram_w),
    .vram_ready(vram_ready), .border(border), .vconfig(vconfig), .intr(intr), .vect(vect)
  );

  always #20 clock_25 = ~clock_25;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] v);
    address = BASE + 16'(off);
    we      = 1'b1;
    data_o  = v;
    @(negedge clock_25);
    we      = 1'b0;
    address = 16'h0000;
    data_o  = 8'h00;
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string name);
    address = BASE + 16'(off);
    we      = 1'b0;
    #1;
    chk(name, 32'(data_rd), 32'(exp));
    @(negedge clock_25);
    address = 16'h0000;
  endtask

  task automatic pix(input logic [3:0] p, input logic [15:0] a, input bit expect_write);
    if (expect_write) exp_q.push_back({a, p});
    wr(3'd2, {4'b0000, p});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock_25);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: one VRAM write per sampled cycle with vram_w (and vram_ready when buffered).
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clock_25);
      #5;
      if (vram_w === 1'b1 && (!FIFO || vram_ready)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL vram unexpected write: got a=%h d=%h expected none", vram_a, vram_d);
        end else begin
          e = exp_q.pop_front();
          chk("vram write", 32'({vram_a, vram_d}), 32'(e));
        end
      end
    end
  end

  initial begin
    #3600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    repeat (2) @(negedge clock_25);
    reset_n = 1'b1;

    // Reset state
    chk("reset vram_w", 32'(vram_w), 32'd0);
    chk("reset intr", 32'(intr), 32'd0);
    chk("vect", 32'(vect), 32'd1);
    chk("reset border", 32'(border), 32'd0);
    chk("reset vconfig", 32'(vconfig), 32'h04);
    rd(3'd0, 8'h00, "reset PTR_L");
    rd(3'd1, 8'h00, "reset PTR_H");
    rd(3'd3, 8'h02, "reset STATUS");

    // Decode boundaries and ignored writes
    address = 16'h001F; #1;
    chk("hit below", 32'(hit), 32'd0);
    chk("data_rd below", 32'(data_rd), 32'd0);
    address = 16'h0027; #1;
    chk("hit top", 32'(hit), 32'd1);
    address = 16'h0028; #1;
    chk("hit above", 32'(hit), 32'd0);
    we = 1'b1; data_o = 8'h0F;
    @(negedge clock_25);
    we = 1'b0; address = 16'h0000; data_o = 8'h00;
    rd(3'd0, 8'h00, "PTR_L after miss write");
    wr(3'd5, 8'hAA);
    rd(3'd5, 8'h00, "TICK_H read-only");
    rd(3'd6, 8'h00, "BORDER unchanged");

    // X-step increment
    wr(3'd7, 8'h04); wr(3'd0, 8'h10); wr(3'd1, 8'h00);
    pix(4'd5, 16'h0010, 1'b1);
    pix(4'd6, 16'h0011, 1'b1);
    pix(4'd7, 16'h0012, 1'b1);
    drain("xstep drain");
    rd(3'd0, 8'h13, "xstep PTR_L");
    rd(3'd1, 8'h00, "xstep PTR_H");

    // Y-step decrement
    wr(3'd7, 8'h18); wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    pix(4'd3, 16'h0100, 1'b1);
    drain("ystep drain");
    rd(3'd0, 8'h00, "ystep PTR_L");
    rd(3'd1, 8'h00, "ystep PTR_H");

    // Pointer wrap upward and downward
    wr(3'd7, 8'h04); wr(3'd0, 8'hFF); wr(3'd1, 8'hFF);
    pix(4'd1, 16'hFFFF, 1'b1);
    drain("wrap drain");
    rd(3'd0, 8'h00, "wrap PTR_L");
    rd(3'd1, 8'h00, "wrap PTR_H");
    wr(3'd7, 8'h14);
    pix(4'd2, 16'h0000, 1'b1);
    drain("underflow drain");
    rd(3'd0, 8'hFF, "underflow PTR_L");
    rd(3'd1, 8'hFF, "underflow PTR_H");

    // Back-pressure and overflow
    vram_ready = 1'b0;
    wr(3'd7, 8'h04); wr(3'd0, 8'h20); wr(3'd1, 8'h00);
    for (int i = 0; i < 9; i++) pix(4'(i + 1), 16'h0020 + 16'(i), FIFO ? (i < 8) : 1'b1);
    rd(3'd3, FIFO ? 8'h09 : 8'h02, "STATUS full ovf");
    rd(3'd0, FIFO ? 8'h28 : 8'h29, "PTR after overflow");
    vram_ready = 1'b1;
    drain("release drain");
    rd(3'd3, FIFO ? 8'h0A : 8'h02, "STATUS drained");
    wr(3'd3, 8'h08);
    rd(3'd3, 8'h02, "STATUS ovf cleared");

    // Reset mid-operation
    wr(3'd6, 8'h0F);
    chk("border set", 32'(border), 32'h0F);
    vram_ready = 1'b0;
    wr(3'd0, 8'h40); wr(3'd1, 8'h00);
    for (int i = 0; i < 4; i++) pix(4'(i + 8), 16'h0040 + 16'(i), !FIFO);
    reset_n = 1'b0;
    @(negedge clock_25);
    reset_n = 1'b1;
    chk("post-reset vram_w", 32'(vram_w), 32'd0);
    chk("post-reset border", 32'(border), 32'd0);
    chk("post-reset vconfig", 32'(vconfig), 32'h04);
    rd(3'd3, 8'h02, "post-reset STATUS");
    rd(3'd0, 8'h00, "post-reset PTR_L");
    rd(3'd1, 8'h00, "post-reset PTR_H");
    chk("post-reset queue", 32'(exp_q.size()), 32'd0);
    vram_ready = 1'b1;

    // Tick counter and interrupt
    wr(3'd7, 8'h84);
    cyc = 0;
    while (intr !== 1'b1 && cyc < 70000) begin
      @(negedge clock_25);
      cyc++;
    end
    chk("intr asserted", 32'(intr), 32'd1);
    chk("tick period window", 32'(cyc >= 63900 && cyc <= 64000), 32'd1);
    chk("vect at irq", 32'(vect), 32'd1);
    rd(3'd3, 8'h06, "STATUS tick_pend");
    wr(3'd3, 8'h04);
    chk("intr cleared", 32'(intr), 32'd0);
    rd(3'd4, 8'h00, "TICK_L");
    rd(3'd5, 8'h01, "TICK_H shadow");
    rd(3'd3, 8'h02, "STATUS pend cleared");

    repeat (3) @(negedge clock_25);
    chk("final queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
